rx_oversample_counter: RTL and testbench

RX_OVERSAMPLE_COUNTER -- requirements
Module: rx_oversample_counter

---
 rtl/rx_oversample_counter.sv | 101 ++++++++++
 tb/tb_rx_oversample_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_oversample_counter.sv
// rx_oversample_counter: oversampling edge and bit counters with mid-bit sample strobes for a UART receiver
module rx_oversample_counter #(
  parameter int MAX_PRESCALE = 32,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [$clog2(MAX_PRESCALE):0]     prescale,
  input  logic                              par_en,
  input  logic                              resync,
  output logic [$clog2(MAX_PRESCALE)-1:0]   edge_cnt,
  output logic [$clog2(DATA_WIDTH+4)-1:0]   bit_cnt,
  output logic                              sample_strobe,
  output logic [1:0]                        sample_idx,
  output logic                              bit_done,
  output logic                              frame_done,
  output logic                              cfg_err
);
  localparam int PW = $clog2(MAX_PRESCALE) + 1;
  localparam int EW = PW - 1;
  localparam int BW = $clog2(DATA_WIDTH + 4);
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;
  state_t        r_state, w_state_nx;
  logic [EW-1:0] r_edge_cnt, w_edge_nx;
  logic [BW-1:0] r_bit_cnt, w_bit_nx;
  logic [PW-1:0] r_ps_lat, w_ps_nx;
  logic [BW-1:0] r_fl_lat, w_fl_nx;
  logic          r_cfg_err, w_cfg_nx;
  logic          w_ps_legal;
  logic          w_active;
  logic [PW-1:0] w_edge_ext;
  logic [PW-1:0] w_half;
  assign edge_cnt = r_edge_cnt;
  assign bit_cnt  = r_bit_cnt;
  assign cfg_err  = r_cfg_err;
  // Strobes are gated by enable so a dropping enable silences them in the same cycle
  always_comb begin
    w_ps_legal    = (32'(prescale) == 8 || 32'(prescale) == 16 || 32'(prescale) == 32) && 32'(prescale) <= MAX_PRESCALE;
    w_active      = (r_state == S_COUNT) && enable;
    w_edge_ext    = {1'b0, r_edge_cnt};
    w_half        = r_ps_lat >> 1;
    bit_done      = w_active && (w_edge_ext == r_ps_lat - PW'(1));
    frame_done    = bit_done && (r_bit_cnt == r_fl_lat - BW'(1));
    sample_strobe = w_active && (w_edge_ext == w_half - PW'(2) || w_edge_ext == w_half - PW'(1) || w_edge_ext == w_half);
    sample_idx    = !sample_strobe ? 2'd0 : w_edge_ext == w_half - PW'(2) ? 2'd0 : w_edge_ext == w_half - PW'(1) ? 2'd1 : 2'd2;
  end
  // Next-state logic: enable low clears counters from any state; resync beats the bit wrap
  always_comb begin
    w_state_nx = r_state;
    w_edge_nx  = r_edge_cnt;
    w_bit_nx   = r_bit_cnt;
    w_ps_nx    = r_ps_lat;
    w_fl_nx    = r_fl_lat;
    w_cfg_nx   = r_cfg_err;
    if (!enable) begin
      w_state_nx = S_IDLE;
      w_edge_nx  = '0;
      w_bit_nx   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nx = S_COUNT;
          w_edge_nx  = '0;
          w_bit_nx   = '0;
          w_ps_nx    = w_ps_legal ? prescale : PW'(16);
          w_fl_nx    = BW'(DATA_WIDTH + 2) + BW'(par_en);
          w_cfg_nx   = !w_ps_legal;
        end
        S_COUNT: begin
          if (frame_done) w_state_nx = S_DONE;
          else if (resync) w_edge_nx = '0;
          else if (bit_done) begin
            w_edge_nx = '0;
            w_bit_nx  = r_bit_cnt + BW'(1);
          end else w_edge_nx = r_edge_cnt + EW'(1);
        end
        S_DONE: w_state_nx = S_DONE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end
  // State and counter registers with asynchronous reset to an idle, 16x default configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_ps_lat   <= PW'(16);
      r_fl_lat   <= BW'(DATA_WIDTH + 2);
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_edge_cnt <= w_edge_nx;
      r_bit_cnt  <= w_bit_nx;
      r_ps_lat   <= w_ps_nx;
      r_fl_lat   <= w_fl_nx;
      r_cfg_err  <= w_cfg_nx;
    end
  end
endmodule

// File: tb/tb_rx_oversample_counter.sv
// tb_rx_oversample_counter: scoreboard bench for frame timing, strobes, resync, enable drop and reset
module tb_rx_oversample_counter;
  logic       clk = 1'b0;
  logic       rst, enable, par_en, resync;
  logic [5:0] prescale;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sample_strobe, bit_done, frame_done, cfg_err;
  logic [1:0] sample_idx;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [3:0] b; logic [4:0] e; logic [1:0] i;} exp_t;
  exp_t q[$];

  rx_oversample_counter #(.MAX_PRESCALE(32), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .prescale(prescale), .par_en(par_en),
    .resync(resync), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sample_strobe(sample_strobe),
    .sample_idx(sample_idx), .bit_done(bit_done), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic en, input logic rs);
    @(negedge clk);
    enable = en;
    resync = rs;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; resync = 1'b0; par_en = 1'b0; prescale = 6'd16;
    @(negedge clk); #1;
    checks++;
    if ({edge_cnt, bit_cnt, sample_strobe, sample_idx, bit_done, frame_done, cfg_err} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got edge=%0d bit=%0d ss=%0b idx=%0d bd=%0b fd=%0b ce=%0b want all 0",
               edge_cnt, bit_cnt, sample_strobe, sample_idx, bit_done, frame_done, cfg_err);
    end
    @(negedge clk); rst = 1'b0;
    step(0, 0);
    checks++;
    if ({edge_cnt, bit_cnt, sample_strobe, bit_done, frame_done, cfg_err} !== 13'd0) begin
      errors++;
      $display("FAIL idle_after_reset got edge=%0d bit=%0d ss=%0b bd=%0b fd=%0b ce=%0b want all 0",
               edge_cnt, bit_cnt, sample_strobe, bit_done, frame_done, cfg_err);
    end
  endtask

  task automatic run_frame(input int ps, input int pe, input int eff, input logic exp_cfg, input string name);
    int fl, k, done_k, bd;
    exp_t ex;
    logic [3:0] hb;
    logic [4:0] he;
    fl = 10 + pe; k = 0; done_k = -1; bd = 0;
    q.delete();
    for (int b = 0; b < fl; b++)
      for (int i = 0; i < 3; i++)
        q.push_back('{b: 4'(b), e: 5'(eff / 2 - 2 + i), i: 2'(i)});
    prescale = 6'(ps); par_en = 1'(pe);
    step(1, 0);
    while (k < eff * fl + 4 && done_k < 0) begin
      step(1, 0);
      k++;
      if (k == 1) begin
        prescale = (ps == 8) ? 6'd32 : 6'd8;
        par_en = ~par_en;
      end
      if (bit_done) bd++;
      if (sample_strobe) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_strobe got b=%0d e=%0d i=%0d want none", name, bit_cnt, edge_cnt, sample_idx);
        end else begin
          ex = q.pop_front();
          if ({bit_cnt, edge_cnt, sample_idx} !== ex) begin
            errors++;
            $display("FAIL %s strobe got b=%0d e=%0d i=%0d want b=%0d e=%0d i=%0d",
                     name, bit_cnt, edge_cnt, sample_idx, ex.b, ex.e, ex.i);
          end
        end
      end
      if (frame_done) done_k = k;
    end
    checks++;
    if (done_k != eff * fl) begin
      errors++;
      $display("FAIL %s frame_done_cycle got %0d want %0d", name, done_k, eff * fl);
    end
    checks++;
    if ({bit_cnt, edge_cnt} !== {4'(fl - 1), 5'(eff - 1)}) begin
      errors++;
      $display("FAIL %s frame_done_pos got b=%0d e=%0d want b=%0d e=%0d", name, bit_cnt, edge_cnt, fl - 1, eff - 1);
    end
    checks++;
    if (bd != fl) begin
      errors++;
      $display("FAIL %s bit_done_count got %0d want %0d", name, bd, fl);
    end
    checks++;
    if (cfg_err !== exp_cfg) begin
      errors++;
      $display("FAIL %s cfg_err got %0b want %0b", name, cfg_err, exp_cfg);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_strobes got %0d left want 0", name, q.size());
    end
    hb = bit_cnt; he = edge_cnt;
    repeat (3) step(1, 0);
    checks++;
    if ({frame_done, bit_done, sample_strobe, bit_cnt, edge_cnt} !== {3'b000, 4'(fl - 1), 5'(eff - 1)}) begin
      errors++;
      $display("FAIL %s done_hold got fd=%0b bd=%0b ss=%0b b=%0d e=%0d want 0 0 0 b=%0d e=%0d",
               name, frame_done, bit_done, sample_strobe, bit_cnt, edge_cnt, hb, he);
    end
    step(0, 0);
    step(0, 0);
    checks++;
    if ({bit_cnt, edge_cnt, cfg_err} !== {9'd0, exp_cfg}) begin
      errors++;
      $display("FAIL %s idle_clear got b=%0d e=%0d ce=%0b want b=0 e=0 ce=%0b", name, bit_cnt, edge_cnt, cfg_err, exp_cfg);
    end
  endtask

  task automatic test_resync;
    prescale = 6'd16; par_en = 1'b0;
    step(1, 0);
    for (int n = 0; n < 200 && !(bit_cnt == 4'd3 && edge_cnt == 5'd4); n++) step(1, 0);
    step(1, 1);
    checks++;
    if ({bit_cnt, edge_cnt} !== {4'd3, 5'd5}) begin
      errors++;
      $display("FAIL resync_reach got b=%0d e=%0d want b=3 e=5", bit_cnt, edge_cnt);
    end
    step(1, 0);
    checks++;
    if ({bit_cnt, edge_cnt} !== {4'd3, 5'd0}) begin
      errors++;
      $display("FAIL resync_realign got b=%0d e=%0d want b=3 e=0", bit_cnt, edge_cnt);
    end
    for (int n = 0; n < 40 && edge_cnt != 5'd14; n++) step(1, 0);
    step(1, 1);
    checks++;
    if ({bit_done, bit_cnt, edge_cnt} !== {1'b1, 4'd3, 5'd15}) begin
      errors++;
      $display("FAIL resync_wrap_cycle got bd=%0b b=%0d e=%0d want bd=1 b=3 e=15", bit_done, bit_cnt, edge_cnt);
    end
    step(1, 0);
    checks++;
    if ({bit_cnt, edge_cnt} !== {4'd3, 5'd0}) begin
      errors++;
      $display("FAIL resync_no_incr got b=%0d e=%0d want b=3 e=0", bit_cnt, edge_cnt);
    end
    step(0, 0);
    step(0, 0);
  endtask

  task automatic test_enable_drop;
    int fd;
    fd = 0;
    prescale = 6'd16; par_en = 1'b0;
    step(1, 0);
    for (int n = 0; n < 200 && !(bit_cnt == 4'd4 && edge_cnt == 5'd6); n++) step(1, 0);
    step(0, 0);
    checks++;
    if ({edge_cnt, sample_strobe, bit_done, frame_done} !== {5'd7, 3'b000}) begin
      errors++;
      $display("FAIL drop_cycle got e=%0d ss=%0b bd=%0b fd=%0b want e=7 0 0 0", edge_cnt, sample_strobe, bit_done, frame_done);
    end
    step(0, 0);
    checks++;
    if ({bit_cnt, edge_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL drop_clear got b=%0d e=%0d want 0 0", bit_cnt, edge_cnt);
    end
    repeat (20) begin
      step(0, 0);
      if (frame_done) fd++;
    end
    checks++;
    if (fd != 0) begin
      errors++;
      $display("FAIL drop_no_frame_done got %0d want 0", fd);
    end
  endtask

  task automatic test_rst_mid;
    int fd;
    fd = 0;
    prescale = 6'd12; par_en = 1'b0;
    step(1, 0);
    repeat (40) step(1, 0);
    checks++;
    if ({cfg_err, bit_cnt} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL rst_pre got ce=%0b b=%0d want ce=1 b=2", cfg_err, bit_cnt);
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if ({edge_cnt, bit_cnt, sample_strobe, sample_idx, bit_done, frame_done, cfg_err} !== 15'd0) begin
      errors++;
      $display("FAIL rst_async got e=%0d b=%0d ss=%0b idx=%0d bd=%0b fd=%0b ce=%0b want all 0",
               edge_cnt, bit_cnt, sample_strobe, sample_idx, bit_done, frame_done, cfg_err);
    end
    repeat (3) step(1, 0);
    checks++;
    if ({edge_cnt, bit_cnt, sample_strobe, bit_done, frame_done, cfg_err} !== 13'd0) begin
      errors++;
      $display("FAIL rst_held got e=%0d b=%0d ss=%0b bd=%0b fd=%0b ce=%0b want all 0",
               edge_cnt, bit_cnt, sample_strobe, bit_done, frame_done, cfg_err);
    end
    enable = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (200) begin
      step(0, 0);
      if (frame_done || edge_cnt != 5'd0) fd++;
    end
    checks++;
    if (fd != 0) begin
      errors++;
      $display("FAIL rst_discard got %0d bad cycles want 0", fd);
    end
  endtask

  initial begin
    test_reset();
    run_frame(8, 0, 8, 1'b0, "ps8");
    run_frame(32, 1, 32, 1'b0, "ps32_par");
    run_frame(12, 0, 16, 1'b1, "ps12_illegal");
    run_frame(16, 0, 16, 1'b0, "ps16_clear");
    run_frame(16, 1, 16, 1'b0, "ps16_par");
    test_resync();
    test_enable_drop();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
